uart_frame_tx_sched: RTL and testbench

Scheduler that owns the UART transmitter and shares it between two requesters: the result-frame streamer and a single-byte acknowledge channel. On a frame request it emits the response frame: header 0xCC, 16-bit big-endian width, 16-bit big-endian height, IMG_W*IMG_H*BPP payload bytes read from the color buffer, then footer 0x33. It sits between the Hough/color-map stage and `uart_tx_module`, replacing ad-hoc TX sequencing in the top level.

---
 rtl/uart_frame_tx_sched.sv | 211 +++++++++++++++++++++
 tb/tb_uart_frame_tx_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx_sched.sv
// Shares one UART transmitter between the result-frame streamer and an ack channel.
// Optional FRAME_CHECKSUM_EN adds an XOR checksum byte before the frame footer.
module uart_frame_tx_sched #(
    parameter int         IMG_W    = 32,
    parameter int         IMG_H    = 32,
    parameter int         BPP      = 3,
    parameter int         ADDR_W   = 12,
    parameter logic [7:0] HDR_BYTE = 8'hCC,
    parameter logic [7:0] FTR_BYTE = 8'h33
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_start,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              ack_valid,
    input  logic [7:0]        ack_data,
    output logic              ack_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy
);

    localparam int COLOR_BYTES = IMG_W * IMG_H * BPP;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(COLOR_BYTES - 1);
    localparam logic [15:0] W16 = 16'(IMG_W);
    localparam logic [15:0] H16 = 16'(IMG_H);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACK,
        S_HDR,
        S_DIM,
        S_FETCH,
        S_PIX,
`ifdef FRAME_CHECKSUM_EN
        S_CSUM,
`endif
        S_FTR,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            r_next;
    logic              r_pend;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_dim;
    logic [7:0]        r_hold;
    logic              r_have;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic       w_hdr_go;
    logic [7:0] w_dim_byte;
    logic [7:0] w_pix_byte;

    // Header is issued on the edge that enters HDR so it lands two cycles after the request.
    assign w_hdr_go = (r_state == S_IDLE) && !ack_valid && r_pend && !tx_busy;

    assign w_pix_byte = r_have ? r_hold : rd_data;

    always_comb begin
        w_dim_byte = 8'h00;
        unique case (r_dim)
            2'd0: w_dim_byte = W16[15:8];
            2'd1: w_dim_byte = W16[7:0];
            2'd2: w_dim_byte = H16[15:8];
            2'd3: w_dim_byte = H16[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= 1'b0;
        end else if (w_hdr_go) begin
            r_pend <= 1'b0;
        end else if (frame_start) begin
            r_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_next     <= S_IDLE;
            r_idx      <= '0;
            r_dim      <= 2'd0;
            r_hold     <= 8'h00;
            r_have     <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            ack_ready  <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            rd_en      <= 1'b0;
            frame_done <= 1'b0;
            ack_ready  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (ack_valid) begin
                        r_state <= S_ACK;
                    end else if (w_hdr_go) begin
                        r_state    <= S_HDR;
                        tx_start   <= 1'b1;
                        tx_data    <= HDR_BYTE;
                        frame_busy <= 1'b1;
                        r_idx      <= '0;
                        r_dim      <= 2'd0;
`ifdef FRAME_CHECKSUM_EN
                        r_csum     <= 8'h00;
`endif
                    end
                end
                S_ACK: begin
                    if (!tx_busy) begin
                        tx_start  <= 1'b1;
                        tx_data   <= ack_data;
                        ack_ready <= 1'b1;
                        r_next    <= S_IDLE;
                        r_state   <= S_GAP;
                    end
                end
                S_HDR: begin
                    r_next  <= S_DIM;
                    r_state <= S_GAP;
                end
                S_DIM: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= w_dim_byte;
                        r_dim    <= r_dim + 2'd1;
                        r_next   <= (r_dim == 2'd3) ? S_FETCH : S_DIM;
                        r_state  <= S_GAP;
                    end
                end
                S_FETCH: begin
                    r_have  <= 1'b0;
                    r_state <= S_PIX;
                end
                S_PIX: begin
                    // Read data is only valid on the first PIX cycle; hold it while UART is busy.
                    if (!r_have) begin
                        r_hold <= rd_data;
                        r_have <= 1'b1;
                    end
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= w_pix_byte;
                        r_have   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
                        r_csum   <= r_csum ^ w_pix_byte;
`endif
                        if (r_idx == LAST_IDX) begin
`ifdef FRAME_CHECKSUM_EN
                            r_next <= S_CSUM;
`else
                            r_next <= S_FTR;
`endif
                        end else begin
                            r_idx  <= r_idx + 1'b1;
                            r_next <= S_FETCH;
                        end
                        r_state <= S_GAP;
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                S_CSUM: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= r_csum;
                        r_next   <= S_FTR;
                        r_state  <= S_GAP;
                    end
                end
`endif
                S_FTR: begin
                    if (!tx_busy) begin
                        tx_start   <= 1'b1;
                        tx_data    <= FTR_BYTE;
                        frame_done <= 1'b1;
                        r_next     <= S_IDLE;
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_state <= r_next;
                    if (r_next == S_FETCH) begin
                        rd_en   <= 1'b1;
                        rd_addr <= r_idx;
                    end
                    if (r_next == S_IDLE) begin
                        frame_busy <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx_sched.sv
// Scoreboard bench for uart_frame_tx_sched with a queue-based frame reference model.
// Honours FRAME_CHECKSUM_EN to expect the XOR checksum byte.
module tb_uart_frame_tx_sched;

    localparam int IMG_W = 2;
    localparam int IMG_H = 2;
    localparam int BPP   = 3;
    localparam int ADDR_W = 4;
    localparam int NB    = IMG_W * IMG_H * BPP;

    logic              clk;
    logic              rst_n;
    logic              frame_start;
    logic              frame_busy;
    logic              frame_done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              ack_valid;
    logic [7:0]        ack_data;
    logic              ack_ready;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;

    logic [7:0] mem [0:NB-1];
    logic [7:0] exp_q [$];
    int checks;
    int errors;
    int tx_count;
    int done_cnt;
    int ack_cnt;
    int byte_time;
    int busy_cnt;

    uart_frame_tx_sched #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BPP(BPP), .ADDR_W(ADDR_W),
        .HDR_BYTE(8'hCC), .FTR_BYTE(8'h33)
    ) dut (
        .clk(clk), .reset_n(rst_n), .frame_start(frame_start),
        .frame_busy(frame_busy), .frame_done(frame_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .ack_valid(ack_valid), .ack_data(ack_data), .ack_ready(ack_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // UART model: busy from the cycle after tx_start for byte_time cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= byte_time;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame();
        logic [7:0] x;
        x = 8'h00;
        exp_q.push_back(8'hCC);
        exp_q.push_back(8'(IMG_W >> 8));
        exp_q.push_back(8'(IMG_W & 255));
        exp_q.push_back(8'(IMG_H >> 8));
        exp_q.push_back(8'(IMG_H & 255));
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(mem[i]);
            x = x ^ mem[i];
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        exp_q.push_back(8'h33);
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n) begin
            if (tx_start) begin
                tx_count++;
                chk("tx_while_busy", {31'd0, tx_busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
                end
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_on_footer", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'h33});
            end
            if (ack_ready) begin
                ack_cnt++;
                chk("ack_issue", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, ack_data});
            end
        end
    end

    task automatic wait_idle();
        int n;
        int stable;
        n = 0;
        stable = 0;
        while (stable < 8 && n < 20000) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && !frame_busy && !tx_busy) stable++;
            else stable = 0;
        end
        if (stable < 8) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d bytes pending expected 0", exp_q.size());
        end
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_ready && n < 5000);
        if (!ack_ready) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack_ready expected pulse");
        end
        ack_valid = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        int n;
        n = 0;
        while (tx_count < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (tx_count < target) begin
            checks++;
            errors++;
            $display("FAIL tx_timeout: got %0d bytes expected %0d", tx_count, target);
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
        chk({tag, "_rd_addr"}, {28'd0, rd_addr}, 32'd0);
        chk({tag, "_frame_busy"}, {31'd0, frame_busy}, 32'd0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_ack_ready"}, {31'd0, ack_ready}, 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int a0;
        int base;
        checks = 0; errors = 0; tx_count = 0; done_cnt = 0; ack_cnt = 0;
        byte_time = 4;
        rst_n = 1'b0; frame_start = 1'b0; ack_valid = 1'b0; ack_data = 8'h00;
        for (int i = 0; i < NB; i++) mem[i] = 8'(i + 1);
        repeat (3) @(negedge clk);
        chk_outputs_reset("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_outputs_reset("post_rst");

        // Directed frame with header latency
        d0 = done_cnt;
        push_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("hdr_not_early", {31'd0, tx_start}, 32'd0);
        chk("busy_not_early", {31'd0, frame_busy}, 32'd0);
        @(negedge clk);
        chk("hdr_latency", {31'd0, tx_start}, 32'd1);
        chk("hdr_byte", {24'd0, tx_data}, 32'hCC);
        chk("busy_rise", {31'd0, frame_busy}, 32'd1);
        wait_idle();
        chk("one_done", done_cnt - d0, 1);
        chk("busy_low_after", {31'd0, frame_busy}, 32'd0);

        // Ack together with frame_start: ack first
        d0 = done_cnt; a0 = ack_cnt;
        ack_data = 8'h5A;
        exp_q.push_back(8'h5A);
        push_frame();
        ack_valid = 1'b1;
        pulse_start();
        wait_ack();
        wait_idle();
        chk("ack_pulses", ack_cnt - a0, 1);
        chk("ack_then_frame", done_cnt - d0, 1);

        // Ack raised mid-payload waits for footer
        d0 = done_cnt;
        base = tx_count;
        push_frame();
        exp_q.push_back(8'h5A);
        pulse_start();
        wait_tx(base + 7);
        ack_data = 8'h5A;
        ack_valid = 1'b1;
        wait_ack();
        chk("ack_after_done", done_cnt - d0, 1);
        wait_idle();

        // Three extra starts during a frame give one more frame
        d0 = done_cnt;
        base = tx_count;
        push_frame();
        push_frame();
        pulse_start();
        wait_tx(base + 3);
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            repeat (3) @(negedge clk);
        end
        wait_idle();
        repeat (50) @(negedge clk);
        chk("one_extra_frame", done_cnt - d0, 2);

        // Reset after the fifth payload byte
        d0 = done_cnt;
        base = tx_count;
        push_frame();
        pulse_start();
        wait_tx(base + 10);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk_outputs_reset("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_done_on_abort", done_cnt - d0, 0);
        chk("idle_after_abort", {31'd0, tx_start | frame_busy}, 32'd0);
        d0 = done_cnt;
        push_frame();
        pulse_start();
        wait_idle();
        chk("frame_after_reset", done_cnt - d0, 1);

        // Randomized frames, optionally preceded by an ack
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
            byte_time = $urandom_range(1, 7);
            d0 = done_cnt; a0 = ack_cnt;
            if ($urandom_range(0, 1) == 1) begin
                ack_data = 8'($urandom);
                exp_q.push_back(ack_data);
                push_frame();
                ack_valid = 1'b1;
                pulse_start();
                wait_ack();
                wait_idle();
                chk("rand_ack", ack_cnt - a0, 1);
            end else begin
                push_frame();
                pulse_start();
                wait_idle();
            end
            chk("rand_done", done_cnt - d0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
